// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings and adder sizing helper
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDC = 2'b10;
  localparam logic [1:0] OP_SUBB = 2'b11;

  function automatic int ngroups(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_pg_group.sv
// rtl/cla_adder_pipe_pg_group.sv - GROUP-bit lookahead block: group P/G and per-bit carries
module pg_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic             gp,
  output logic             gg,
  output logic [GROUP-1:0] c
);

  // c[i] is the carry into bit i of the group; gg assumes a zero carry-in
  always_comb begin
    logic carry;
    logic gen;
    gp    = &p;
    gen   = 1'b0;
    carry = cin;
    c     = '0;
    for (int i = 0; i < GROUP; i++) begin
      c[i]  = carry;
      carry = g[i] | (p[i] & carry);
      gen   = g[i] | (p[i] & gen);
    end
    gg = gen;
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - two-stage pipelined carry-lookahead add/sub with valid/ready
module cla_adder_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = ngroups(WIDTH, GROUP);

  if ((WIDTH % GROUP) != 0 || !(GROUP == 2 || GROUP == 4 || GROUP == 8)) begin : g_param_err
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP, GROUP must be 2, 4 or 8");
  end

  logic [WIDTH-1:0] b_eff, p_in, g_in, unused_c_in;
  logic [NG-1:0]    gp_in, gg_in;
  logic             c0_in;

  assign b_eff = op[0] ? ~b : b;
  assign c0_in = op[1] ? cin : (op == OP_SUB);
  assign p_in  = a ^ b_eff;
  assign g_in  = a & b_eff;

  for (genvar k = 0; k < NG; k++) begin : g_s1
    pg_group #(.GROUP(GROUP)) u_pg (
      .p   (p_in[k*GROUP +: GROUP]),
      .g   (g_in[k*GROUP +: GROUP]),
      .cin (1'b0),
      .gp  (gp_in[k]),
      .gg  (gg_in[k]),
      .c   (unused_c_in[k*GROUP +: GROUP])
    );
  end

  logic             v1, c01;
  logic [WIDTH-1:0] p1, g1;
  logic [NG-1:0]    gp1, gg1;
  logic             v2;
  logic             adv1, adv2;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      c01 <= 1'b0;
      p1  <= '0;
      g1  <= '0;
      gp1 <= '0;
      gg1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        c01 <= c0_in;
        p1  <= p_in;
        g1  <= g_in;
        gp1 <= gp_in;
        gg1 <= gg_in;
      end
    end
  end

  // Group carry chain: gc[k] is the carry into group k, gc[NG] the adder carry-out
  logic [NG:0] gc;
  always_comb begin
    logic carry;
    carry = c01;
    gc    = '0;
    for (int k = 0; k < NG; k++) begin
      gc[k] = carry;
      carry = gg1[k] | (gp1[k] & carry);
    end
    gc[NG] = carry;
  end

  logic [WIDTH-1:0] bc, sum_n;
  logic [NG-1:0]    unused_gp2, unused_gg2;

  for (genvar k = 0; k < NG; k++) begin : g_s2
    pg_group #(.GROUP(GROUP)) u_pg (
      .p   (p1[k*GROUP +: GROUP]),
      .g   (g1[k*GROUP +: GROUP]),
      .cin (gc[k]),
      .gp  (unused_gp2[k]),
      .gg  (unused_gg2[k]),
      .c   (bc[k*GROUP +: GROUP])
    );
  end

  assign sum_n = p1 ^ bc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        sum  <= sum_n;
        cout <= gc[NG];
        ovf  <= bc[WIDTH-1] ^ gc[NG];
        zero <= ~|sum_n;
      end
    end
  end

  assign out_valid = v2;

endmodule
